coax_host_bridge: RTL and testbench
===================================

COAX_HOST_BRIDGE -- requirements
Module: coax_host_bridge

Interface
REQ-001 Parameters SHALL be: DEPTH, default 16, FIFO depth per direction, power of two, 4..256; TX_W, default 10, transmit word width; RX_W, default 12, receive word width; DIV_RST, default 8'd2, reset value of the bit-tick divider.
REQ-002 Ports, clock and reset first: clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-003 Bus ports: addr in 12, byte address, only addr[4:2] decoded; write in 32, write data; en in 1, access strobe; wen in 4, byte write enables, any bit set means write; read out 32, registered read data.
REQ-004 Transmitter-side ports: tx_word out TX_W, TX FIFO head; tx_valid out 1, TX FIFO non-empty; tx_pop in 1, consume head; tx_active in 1, line busy.
REQ-005 Receiver-side ports: rx_word in RX_W, received word; rx_valid in 1, one-cycle push strobe; rx_active in 1, line busy.
REQ-006 Control ports: bit_tick out 1, one-cycle bit-rate strobe; core_rst out 1, rst OR soft reset, to transmitter and receiver; irq out 1, level interrupt.

Function
REQ-007 Register map by addr[4:2]: 0 TXDATA, 1 RXDATA, 2 TXSTAT, 3 RXSTAT, 4 CTRL, 5 IRQEN, 6 IRQSTAT; 7 SHALL read 0 and ignore writes.
REQ-008 A read SHALL occur when en=1 and wen=0; read SHALL update on the next clock edge, 1-cycle latency; read SHALL hold its value when en=0.
REQ-009 A write SHALL occur when en=1 and wen!=0.
REQ-010 TXDATA write SHALL push write[TX_W-1:0] and latch it as last-written; TXDATA read SHALL return the zero-extended last-written value.
REQ-011 TXDATA write while the TX FIFO holds DEPTH entries SHALL drop the word and set sticky IRQSTAT[3] (tx_ovf).
REQ-012 RXDATA read SHALL return {zeros, head} and pop in the same cycle; when empty it SHALL return 0 with no state change.
REQ-013 rx_valid while the RX FIFO holds DEPTH entries SHALL drop rx_word and set sticky IRQSTAT[2] (rx_ovf).
REQ-014 Simultaneous push and pop:
  - when full, both SHALL execute and occupancy SHALL be unchanged;
  - when empty, only the push SHALL execute;
  - tx_pop when empty SHALL be ignored.
REQ-015 Occupancy width SHALL be clog2(DEPTH)+1; pointers SHALL wrap modulo DEPTH with no lost or duplicated words.
REQ-016 TXSTAT read SHALL return {tx_active, 14'b0, full, 7'b0, occupancy zero-extended to 9 bits}, i.e. bit31 tx_active, bit16 full, bits[8:0] occupancy. RXSTAT SHALL use the same layout with rx_active.
REQ-017 CTRL bits[15:8] SHALL be DIV (read/write).
REQ-018 CTRL bit0 write of 1 SHALL assert soft reset for exactly one cycle; bit0 SHALL read 0.
REQ-019 Soft reset SHALL empty both FIFOs and clear IRQSTAT; DIV, IRQEN and last-written TXDATA SHALL be retained.
REQ-020 bit_tick SHALL pulse for one cycle every DIV+1 clk cycles; DIV=0 SHALL give bit_tick=1 continuously.
REQ-021 Any CTRL write SHALL restart the divider count from 0; the first pulse at the new DIV SHALL come DIV+1 cycles after the write.
REQ-022 IRQSTAT bits: bit0 rx_nonempty, live level; bit1 tx_empty, live level; bit2 rx_ovf, sticky; bit3 tx_ovf, sticky. A write of 1 SHALL clear a sticky bit; writes to level bits SHALL be ignored.
REQ-023 When a set event and a clear of the same bit occur in one cycle, set SHALL win.
REQ-024 irq SHALL be registered OR of (IRQSTAT[3:0] & IRQEN[3:0]), 1 cycle after the cause.

Reset
REQ-025 On rst both FIFOs SHALL empty; read=0; irq=0; IRQEN=0; sticky bits=0; TXDATA last-written=0; DIV=DIV_RST; divider count=0; soft-reset pulse=0.
REQ-026 core_rst SHALL be 1 during rst.
REQ-027 rst asserted mid-transfer SHALL discard all buffered words, with no push or pop in that cycle.

Verification
REQ-028 Scenario 1: after rst, read TXSTAT -> 0x00000000; read IRQSTAT -> 0x2 (tx_empty); read CTRL -> 0x00000200.
REQ-029 Scenario 2: write TXDATA 0x3A5 x3 -> tx_valid=1, tx_word=0x3A5, TXSTAT[8:0]=3; pulse tx_pop x3 -> tx_valid=0, occupancy 0.
REQ-030 Scenario 3: DEPTH=16, 17 rx_valid pushes 0x001..0x011 -> RXSTAT bit16=1, occupancy 16, IRQSTAT[2]=1; 16 RXDATA reads -> 0x001..0x010 in order; 17th read -> 0.
REQ-031 Scenario 4: IRQEN=0x4, overflow RX -> irq=1 one cycle later; write IRQSTAT 0x4 -> irq=0; clear coinciding with a new overflow -> bit stays 1.
REQ-032 Scenario 5: write CTRL DIV=4 -> bit_tick period 5 cycles, first pulse 5 cycles after the write; DIV=0 -> bit_tick constant 1.
REQ-033 Scenario 6: with 5 words queued each way, write CTRL bit0=1 -> core_rst one cycle, both occupancies 0, DIV retained; simultaneous push+pop on a full TX FIFO -> occupancy stays 16.

Source files
------------

// File: rtl/coax_host_bridge.sv
// Host-side register bridge for a coax link: 32-bit register bus in front of
// a TX word FIFO, an RX word FIFO, a bit-rate divider and an interrupt block.
module coax_host_bridge #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TX_W    = 10,
  parameter int unsigned RX_W    = 12,
  parameter logic [7:0]  DIV_RST = 8'd2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     addr,
  input  logic [31:0]     write,
  input  logic            en,
  input  logic [3:0]      wen,
  output logic [31:0]     read,
  output logic [TX_W-1:0] tx_word,
  output logic            tx_valid,
  input  logic            tx_pop,
  input  logic            tx_active,
  input  logic [RX_W-1:0] rx_word,
  input  logic            rx_valid,
  input  logic            rx_active,
  output logic            bit_tick,
  output logic            core_rst,
  output logic            irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  localparam logic [2:0] A_TXDATA  = 3'd0;
  localparam logic [2:0] A_RXDATA  = 3'd1;
  localparam logic [2:0] A_TXSTAT  = 3'd2;
  localparam logic [2:0] A_RXSTAT  = 3'd3;
  localparam logic [2:0] A_CTRL    = 3'd4;
  localparam logic [2:0] A_IRQEN   = 3'd5;
  localparam logic [2:0] A_IRQSTAT = 3'd6;

  // Bus decode
  logic [2:0] w_sel;
  logic       w_rd;
  logic       w_wr;
  logic       w_wr_tx;
  logic       w_wr_ctrl;
  logic       w_wr_irqen;
  logic       w_wr_irqst;
  logic       w_rd_rx;
  logic       w_flush;

  assign w_sel      = addr[4:2];
  assign w_rd       = en & (wen == 4'd0);
  assign w_wr       = en & (wen != 4'd0);
  assign w_wr_tx    = w_wr & (w_sel == A_TXDATA);
  assign w_wr_ctrl  = w_wr & (w_sel == A_CTRL);
  assign w_wr_irqen = w_wr & (w_sel == A_IRQEN);
  assign w_wr_irqst = w_wr & (w_sel == A_IRQSTAT);
  assign w_rd_rx    = w_rd & (w_sel == A_RXDATA);

  // Registers
  logic              r_soft_rst;
  logic [7:0]        r_div;
  logic [7:0]        r_div_cnt;
  logic              r_tick;
  logic [3:0]        r_irqen;
  logic              r_rx_ovf;
  logic              r_tx_ovf;
  logic              r_irq;
  logic [TX_W-1:0]   r_tx_last;
  logic [31:0]       r_read;

  logic [TX_W-1:0]   r_tx_mem [DEPTH];
  logic [AW-1:0]     r_tx_wp;
  logic [AW-1:0]     r_tx_rp;
  logic [OW-1:0]     r_tx_cnt;
  logic [RX_W-1:0]   r_rx_mem [DEPTH];
  logic [AW-1:0]     r_rx_wp;
  logic [AW-1:0]     r_rx_rp;
  logic [OW-1:0]     r_rx_cnt;

  // Hard or soft reset both flush the FIFOs and block any transfer that cycle
  assign w_flush = rst | r_soft_rst;

  // TX FIFO control: a push into a full FIFO is accepted only alongside a pop
  logic w_tx_full;
  logic w_tx_empty;
  logic w_tx_pop;
  logic w_tx_push;
  logic w_tx_ovf;

  assign w_tx_full  = (r_tx_cnt == OW'(DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_pop   = tx_pop & ~w_tx_empty & ~w_flush;
  assign w_tx_push  = w_wr_tx & (~w_tx_full | w_tx_pop) & ~w_flush;
  assign w_tx_ovf   = w_wr_tx & w_tx_full & ~w_tx_pop & ~w_flush;

  // RX FIFO control: popped by RXDATA reads, pushed by the receiver
  logic w_rx_full;
  logic w_rx_empty;
  logic w_rx_pop;
  logic w_rx_push;
  logic w_rx_ovf;

  assign w_rx_full  = (r_rx_cnt == OW'(DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_pop   = w_rd_rx & ~w_rx_empty & ~w_flush;
  assign w_rx_push  = rx_valid & (~w_rx_full | w_rx_pop) & ~w_flush;
  assign w_rx_ovf   = rx_valid & w_rx_full & ~w_rx_pop & ~w_flush;

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wp] <= write[TX_W-1:0];
    end
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || r_soft_rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + OW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - OW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wp] <= rx_word;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || r_soft_rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + OW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - OW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Control registers that survive a soft reset; soft reset is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_soft_rst <= 1'b0;
      r_div      <= DIV_RST;
      r_irqen    <= 4'd0;
      r_tx_last  <= '0;
    end else begin
      r_soft_rst <= w_wr_ctrl & write[0];
      if (w_wr_ctrl)  r_div     <= write[15:8];
      if (w_wr_irqen) r_irqen   <= write[3:0];
      if (w_wr_tx)    r_tx_last <= write[TX_W-1:0];
    end
  end

  // Sticky overflow flags: write-1-to-clear, a same-cycle set wins
  always_ff @(posedge clk) begin
    if (rst || r_soft_rst) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      r_rx_ovf <= w_rx_ovf | (r_rx_ovf & ~(w_wr_irqst & write[2]));
      r_tx_ovf <= w_tx_ovf | (r_tx_ovf & ~(w_wr_irqst & write[3]));
    end
  end

  // Bit-rate divider: tick is registered from the next count so a CTRL write
  // places the first pulse exactly DIV+1 cycles later
  logic [7:0] w_cnt_nxt;
  assign w_cnt_nxt = (r_div_cnt == r_div) ? 8'd0 : r_div_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= 8'd0;
      r_tick    <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_div_cnt <= 8'd0;
      r_tick    <= (write[15:8] == 8'd0);
    end else begin
      r_div_cnt <= w_cnt_nxt;
      r_tick    <= (w_cnt_nxt == r_div);
    end
  end

  // Interrupt status view and registered interrupt line
  logic [3:0] w_irqstat;
  assign w_irqstat = {r_tx_ovf, r_rx_ovf, w_tx_empty, ~w_rx_empty};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_irqstat & r_irqen);
    end
  end

  // Read data mux
  logic [31:0] w_rd_data;
  always_comb begin
    w_rd_data = 32'd0;
    case (w_sel)
      A_TXDATA:  w_rd_data = 32'(r_tx_last);
      A_RXDATA:  w_rd_data = w_rx_empty ? 32'd0 : 32'(r_rx_mem[r_rx_rp]);
      A_TXSTAT:  w_rd_data = {tx_active, 14'd0, w_tx_full, 7'd0, 9'(r_tx_cnt)};
      A_RXSTAT:  w_rd_data = {rx_active, 14'd0, w_rx_full, 7'd0, 9'(r_rx_cnt)};
      A_CTRL:    w_rd_data = {16'd0, r_div, 8'd0};
      A_IRQEN:   w_rd_data = {28'd0, r_irqen};
      A_IRQSTAT: w_rd_data = {28'd0, w_irqstat};
      default:   w_rd_data = 32'd0;
    endcase
  end

  // Registered read port, holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read <= 32'd0;
    end else if (w_rd) begin
      r_read <= w_rd_data;
    end
  end

  // Address and data bits outside the decoded register fields
  logic w_unused;
  assign w_unused = &{1'b0, addr[11:5], addr[1:0], write[31:16]};

  assign read     = r_read;
  assign tx_word  = r_tx_mem[r_tx_rp];
  assign tx_valid = ~w_tx_empty;
  assign bit_tick = r_tick;
  assign core_rst = rst | r_soft_rst;
  assign irq      = r_irq;

endmodule

// File: tb/tb_coax_host_bridge.sv
// Self-checking bench for coax_host_bridge: register reads are scored against
// a queue of expected values; FIFO contents are tracked by queue models.
module tb_coax_host_bridge;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TX_W  = 10;
  localparam int unsigned RX_W  = 12;

  localparam logic [2:0] R_TXDATA  = 3'd0;
  localparam logic [2:0] R_RXDATA  = 3'd1;
  localparam logic [2:0] R_TXSTAT  = 3'd2;
  localparam logic [2:0] R_RXSTAT  = 3'd3;
  localparam logic [2:0] R_CTRL    = 3'd4;
  localparam logic [2:0] R_IRQEN   = 3'd5;
  localparam logic [2:0] R_IRQSTAT = 3'd6;
  localparam logic [2:0] R_NONE    = 3'd7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [11:0]     addr = '0;
  logic [31:0]     write = '0;
  logic            en = 1'b0;
  logic [3:0]      wen = '0;
  logic [31:0]     read;
  logic [TX_W-1:0] tx_word;
  logic            tx_valid;
  logic            tx_pop = 1'b0;
  logic            tx_active = 1'b0;
  logic [RX_W-1:0] rx_word = '0;
  logic            rx_valid = 1'b0;
  logic            rx_active = 1'b0;
  logic            bit_tick;
  logic            core_rst;
  logic            irq;

  always #5 clk = ~clk;

  coax_host_bridge #(
    .DEPTH(DEPTH), .TX_W(TX_W), .RX_W(RX_W), .DIV_RST(8'd2)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .write(write), .en(en), .wen(wen),
    .read(read), .tx_word(tx_word), .tx_valid(tx_valid), .tx_pop(tx_pop),
    .tx_active(tx_active), .rx_word(rx_word), .rx_valid(rx_valid),
    .rx_active(rx_active), .bit_tick(bit_tick), .core_rst(core_rst), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]     q_exp  [$];
  string           q_name [$];
  logic [TX_W-1:0] tx_model [$];
  logic [RX_W-1:0] rx_model [$];
  logic [31:0]     last_read = '0;

  function automatic logic [11:0] ra(input logic [2:0] idx);
    return {7'd0, idx, 2'b00};
  endfunction

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
    @(negedge clk);
    addr = ra(idx); write = d; en = 1'b1; wen = 4'hF;
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
  endtask

  // Issue a read, score the registered result one cycle later
  task automatic bus_read(input logic [2:0] idx, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string       s;
    @(negedge clk);
    addr = ra(idx); en = 1'b1; wen = 4'h0;
    q_exp.push_back(exp);
    q_name.push_back(nm);
    @(negedge clk);
    en = 1'b0;
    e = q_exp.pop_front();
    s = q_name.pop_front();
    n_checks++;
    if (read !== e) begin
      n_fail++;
      $display("FAIL %s: read=0x%08h expected=0x%08h", s, read, e);
    end
    last_read = e;
  endtask

  task automatic rx_read(input string nm);
    logic [31:0] e;
    e = (rx_model.size() > 0) ? 32'(rx_model.pop_front()) : 32'd0;
    bus_read(R_RXDATA, e, nm);
  endtask

  task automatic tx_write(input logic [TX_W-1:0] w);
    @(negedge clk);
    addr = ra(R_TXDATA); write = 32'(w); en = 1'b1; wen = 4'h1;
    if (tx_model.size() < DEPTH) tx_model.push_back(w);
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
  endtask

  task automatic tx_pop_one();
    logic [TX_W-1:0] e;
    @(negedge clk);
    if (tx_model.size() > 0) begin
      e = tx_model.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_word !== e) begin
        n_fail++;
        $display("FAIL tx_head: valid=%0b word=0x%03h expected valid=1 word=0x%03h", tx_valid, tx_word, e);
      end
    end
    tx_pop = 1'b1;
    @(negedge clk);
    tx_pop = 1'b0;
  endtask

  task automatic rx_push(input logic [RX_W-1:0] w);
    @(negedge clk);
    rx_valid = 1'b1; rx_word = w;
    if (rx_model.size() < DEPTH) rx_model.push_back(w);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (core_rst !== 1'b1 || read !== 32'd0 || irq !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: core_rst=%0b read=0x%08h irq=%0b tx_valid=%0b expected 1/0/0/0",
               core_rst, read, irq, tx_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (core_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL core_rst_release: core_rst=%0b expected 0", core_rst);
    end
    bus_read(R_TXSTAT,  32'h0000_0000, "txstat_rst");
    bus_read(R_IRQSTAT, 32'h0000_0002, "irqstat_rst");
    bus_read(R_CTRL,    32'h0000_0200, "ctrl_rst");
    bus_read(R_IRQEN,   32'h0000_0000, "irqen_rst");
    bus_read(R_TXDATA,  32'h0000_0000, "txdata_rst");
    rx_read("rxdata_rst");
  endtask

  task automatic test_tx_basic();
    repeat (3) tx_write(10'h3A5);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_word !== 10'h3A5) begin
      n_fail++;
      $display("FAIL tx_head3: valid=%0b word=0x%03h expected valid=1 word=0x3a5", tx_valid, tx_word);
    end
    bus_read(R_TXSTAT, 32'h0000_0003, "txstat_3");
    bus_read(R_TXDATA, 32'h0000_03A5, "txdata_last");
    tx_active = 1'b1;
    bus_read(R_TXSTAT, 32'h8000_0003, "txstat_active");
    tx_active = 1'b0;
    repeat (3) tx_pop_one();
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_drained: tx_valid=%0b expected 0", tx_valid);
    end
    bus_read(R_TXSTAT, 32'h0000_0000, "txstat_0");
    tx_pop_one();
    bus_read(R_TXSTAT, 32'h0000_0000, "txstat_pop_empty");
    tx_write(10'h155);
    tx_pop_one();
    bus_read(R_TXDATA, 32'h0000_0155, "txdata_last2");
  endtask

  task automatic test_rx_overflow();
    for (int i = 1; i <= 17; i++) rx_push(RX_W'(i));
    bus_read(R_RXSTAT, 32'h0001_0010, "rxstat_full");
    bus_read(R_IRQSTAT, 32'h0000_0007, "irqstat_rxovf");
    rx_active = 1'b1;
    bus_read(R_RXSTAT, 32'h8001_0010, "rxstat_active");
    rx_active = 1'b0;
    for (int i = 0; i < 16; i++) rx_read("rxdata_order");
    rx_read("rxdata_empty");
    bus_read(R_IRQSTAT, 32'h0000_0006, "irqstat_rx_drained");
    bus_write(R_IRQSTAT, 32'h0000_0007);
    bus_read(R_IRQSTAT, 32'h0000_0002, "irqstat_clear");
  endtask

  task automatic test_irq();
    bus_write(R_IRQEN, 32'h4);
    for (int i = 0; i < 16; i++) rx_push(RX_W'(12'h100 + i));
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_idle: irq=%0b expected 0", irq);
    end
    rx_push(12'h1FF);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set: irq=%0b expected 1", irq);
    end
    bus_write(R_IRQSTAT, 32'h4);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clr: irq=%0b expected 0", irq);
    end
    // clear and a fresh overflow land in the same cycle
    @(negedge clk);
    addr = ra(R_IRQSTAT); write = 32'h4; en = 1'b1; wen = 4'hF;
    rx_valid = 1'b1; rx_word = 12'h2FF;
    @(negedge clk);
    en = 1'b0; wen = 4'h0; rx_valid = 1'b0;
    bus_read(R_IRQSTAT, 32'h0000_0007, "irqstat_set_wins");
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set_wins: irq=%0b expected 1", irq);
    end
    for (int i = 0; i < 16; i++) rx_read("rxdata_irq_drain");
    bus_write(R_IRQSTAT, 32'h4);
    bus_write(R_IRQEN, 32'h0);
  endtask

  task automatic test_divider();
    bus_write(R_CTRL, 32'h0000_0400);
    for (int i = 1; i <= 10; i++) begin
      n_checks++;
      if (bit_tick !== ((i % 5) == 0)) begin
        n_fail++;
        $display("FAIL tick_div4: cycle=%0d tick=%0b expected=%0b", i, bit_tick, ((i % 5) == 0));
      end
      @(negedge clk);
    end
    bus_read(R_CTRL, 32'h0000_0400, "ctrl_div4");
    bus_write(R_CTRL, 32'h0000_0000);
    for (int i = 1; i <= 6; i++) begin
      n_checks++;
      if (bit_tick !== 1'b1) begin
        n_fail++;
        $display("FAIL tick_div0: cycle=%0d tick=%0b expected=1", i, bit_tick);
      end
      @(negedge clk);
    end
    bus_write(R_CTRL, 32'h0000_0200);
  endtask

  task automatic test_soft_reset();
    bus_write(R_CTRL, 32'h0000_0500);
    bus_write(R_IRQEN, 32'h3);
    for (int i = 0; i < 5; i++) begin
      tx_write(TX_W'(10'h0A0 + i));
      rx_push(RX_W'(12'h0B0 + i));
    end
    bus_read(R_TXSTAT, 32'h0000_0005, "txstat_5");
    bus_read(R_RXSTAT, 32'h0000_0005, "rxstat_5");
    bus_write(R_CTRL, 32'h0000_0501);
    n_checks++;
    if (core_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL soft_rst_pulse: core_rst=%0b expected 1", core_rst);
    end
    @(negedge clk);
    n_checks++;
    if (core_rst !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_rst_end: core_rst=%0b tx_valid=%0b expected 0/0", core_rst, tx_valid);
    end
    tx_model.delete();
    rx_model.delete();
    bus_read(R_TXSTAT,  32'h0000_0000, "txstat_soft");
    bus_read(R_RXSTAT,  32'h0000_0000, "rxstat_soft");
    bus_read(R_CTRL,    32'h0000_0500, "ctrl_soft");
    bus_read(R_IRQEN,   32'h0000_0003, "irqen_soft");
    bus_read(R_TXDATA,  32'h0000_00A4, "txdata_soft");
    bus_read(R_IRQSTAT, 32'h0000_0002, "irqstat_soft");
    rx_read("rxdata_soft");
    bus_write(R_IRQEN, 32'h0);
    bus_write(R_CTRL, 32'h0000_0200);
  endtask

  task automatic test_back_to_back();
    logic [TX_W-1:0] e;
    for (int i = 0; i < 16; i++) tx_write(TX_W'(10'h200 + i));
    bus_read(R_TXSTAT, 32'h0001_0010, "txstat_full");
    tx_write(10'h3FF);
    bus_read(R_IRQSTAT, 32'h0000_0008, "irqstat_txovf");
    // push and pop together on a full FIFO
    @(negedge clk);
    e = tx_model.pop_front();
    n_checks++;
    if (tx_word !== e) begin
      n_fail++;
      $display("FAIL tx_head_full: word=0x%03h expected=0x%03h", tx_word, e);
    end
    tx_model.push_back(10'h321);
    addr = ra(R_TXDATA); write = 32'h321; en = 1'b1; wen = 4'h8; tx_pop = 1'b1;
    @(negedge clk);
    en = 1'b0; wen = 4'h0; tx_pop = 1'b0;
    bus_read(R_TXSTAT, 32'h0001_0010, "txstat_full_pushpop");
    bus_read(R_IRQSTAT, 32'h0000_0008, "irqstat_no_new_ovf");
    for (int i = 0; i < 16; i++) tx_pop_one();
    bus_read(R_TXSTAT, 32'h0000_0000, "txstat_wrapped_empty");
    // push and pop together on an empty FIFO: only the push happens
    @(negedge clk);
    tx_model.push_back(10'h0F0);
    addr = ra(R_TXDATA); write = 32'h0F0; en = 1'b1; wen = 4'hF; tx_pop = 1'b1;
    @(negedge clk);
    en = 1'b0; wen = 4'h0; tx_pop = 1'b0;
    bus_read(R_TXSTAT, 32'h0000_0001, "txstat_empty_pushpop");
    tx_pop_one();
    bus_write(R_IRQSTAT, 32'h8);
    bus_read(R_IRQSTAT, 32'h0000_0002, "irqstat_txovf_clr");
  endtask

  task automatic test_unmapped_and_hold();
    bus_write(R_NONE, 32'hFFFF_FFFF);
    bus_read(R_NONE,  32'h0000_0000, "reg7");
    bus_read(R_IRQEN, 32'h0000_0000, "irqen_after_reg7");
    bus_read(R_CTRL,  32'h0000_0200, "ctrl_after_reg7");
    repeat (3) @(negedge clk);
    n_checks++;
    if (read !== last_read) begin
      n_fail++;
      $display("FAIL read_hold: read=0x%08h expected=0x%08h", read, last_read);
    end
  endtask

  task automatic test_rst_midstream();
    for (int i = 0; i < 3; i++) begin
      tx_write(TX_W'(10'h050 + i));
      rx_push(RX_W'(12'h060 + i));
    end
    bus_write(R_CTRL, 32'h0000_0700);
    @(negedge clk);
    rst = 1'b1; tx_pop = 1'b1; rx_valid = 1'b1; rx_word = 12'h777;
    @(negedge clk);
    rst = 1'b0; tx_pop = 1'b0; rx_valid = 1'b0;
    tx_model.delete();
    rx_model.delete();
    n_checks++;
    if (tx_valid !== 1'b0 || read !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid: tx_valid=%0b read=0x%08h expected 0/0", tx_valid, read);
    end
    bus_read(R_TXSTAT,  32'h0000_0000, "txstat_rst_mid");
    bus_read(R_RXSTAT,  32'h0000_0000, "rxstat_rst_mid");
    bus_read(R_IRQSTAT, 32'h0000_0002, "irqstat_rst_mid");
    bus_read(R_CTRL,    32'h0000_0200, "ctrl_rst_mid");
    bus_read(R_TXDATA,  32'h0000_0000, "txdata_rst_mid");
    rx_read("rxdata_rst_mid");
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_overflow();
    test_irq();
    test_divider();
    test_soft_reset();
    test_back_to_back();
    test_unmapped_and_hold();
    test_rst_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
